// File: rtl/hansen_pkg.sv
// Shared types and helpers for the hansen core memory subsystem.
package hansen_pkg;

    localparam int HANSEN_XLEN = 32;

    typedef enum logic {PORT_I, PORT_D} port_e;
    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    // Misaligned or beyond a RAM of 2**aw words.
    function automatic logic addr_err(input logic [HANSEN_XLEN-1:0] addr, input int aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != '0);
    endfunction

endpackage

// File: rtl/hansen_bram_sp.sv
// Single-port synchronous RAM with byte write enables and 1-cycle registered read.
module hansen_bram_sp
    import hansen_pkg::*;
#(
    parameter int DEPTH = 512,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   en,
    input  logic [3:0]             be,
    input  logic [AW-1:0]          addr,
    input  logic [HANSEN_XLEN-1:0] wdata,
    output logic [HANSEN_XLEN-1:0] rdata
);

    logic [HANSEN_XLEN-1:0] mem [DEPTH];
    logic [HANSEN_XLEN-1:0] rdata_q;

    // Read-before-write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
            end
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/hansen_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the I-fetch and data ports,
// with a post-reset clear sequencer and address range/alignment checking.
module hansen_mem_arbiter
    import hansen_pkg::*;
#(
    parameter int DEPTH          = 512,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_req,
    input  logic [HANSEN_XLEN-1:0] i_addr,
    output logic                   i_gnt,
    output logic                   i_rvalid,
    output logic [HANSEN_XLEN-1:0] i_rdata,
    output logic                   i_err,
    input  logic                   d_req,
    input  logic                   d_we,
    input  logic [3:0]             d_be,
    input  logic [HANSEN_XLEN-1:0] d_addr,
    input  logic [HANSEN_XLEN-1:0] d_wdata,
    output logic                   d_gnt,
    output logic                   d_rvalid,
    output logic [HANSEN_XLEN-1:0] d_rdata,
    output logic                   d_err,
    output logic                   busy
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_WRD = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    port_e         last_gnt_q, last_gnt_d;

    logic i_rvalid_q, i_err_q, d_rvalid_q, d_err_q, d_rd_q;

    logic                   ram_en;
    logic [3:0]             ram_be;
    logic [AW-1:0]          ram_addr;
    logic [HANSEN_XLEN-1:0] ram_wdata, ram_rdata;

    logic run, i_bad, d_bad, gi, gd;

    assign run   = (state_q == ST_RUN);
    assign i_bad = addr_err(i_addr, AW);
    assign d_bad = addr_err(d_addr, AW);
    // On contention the port not granted last wins.
    assign gi    = run && i_req && (!d_req || last_gnt_q == PORT_D);
    assign gd    = run && d_req && (!i_req || last_gnt_q == PORT_I);

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        last_gnt_d = last_gnt_q;
        ram_en     = 1'b0;
        ram_be     = 4'h0;
        ram_addr   = clr_cnt_q;
        ram_wdata  = '0;
        if (!run) begin
            ram_en    = 1'b1;
            ram_be    = 4'hF;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_WRD) state_d = ST_RUN;
        end else if (gd) begin
            ram_en     = !d_bad;
            ram_be     = d_we ? d_be : 4'h0;
            ram_addr   = d_addr[AW+1:2];
            ram_wdata  = d_wdata;
            last_gnt_d = PORT_D;
        end else if (gi) begin
            ram_en     = !i_bad;
            ram_addr   = i_addr[AW+1:2];
            last_gnt_d = PORT_I;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt_q  <= '0;
            last_gnt_q <= PORT_I;
            i_rvalid_q <= 1'b0;
            i_err_q    <= 1'b0;
            d_rvalid_q <= 1'b0;
            d_err_q    <= 1'b0;
            d_rd_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            last_gnt_q <= last_gnt_d;
            i_rvalid_q <= gi;
            i_err_q    <= gi && i_bad;
            d_rvalid_q <= gd;
            d_err_q    <= gd && d_bad;
            d_rd_q     <= gd && !d_we && !d_bad;
        end
    end

    hansen_bram_sp #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // RAM output is shared; only the port that owns a good read sees it.
    assign i_gnt    = gi;
    assign d_gnt    = gd;
    assign i_rvalid = i_rvalid_q;
    assign i_err    = i_err_q;
    assign i_rdata  = (i_rvalid_q && !i_err_q) ? ram_rdata : '0;
    assign d_rvalid = d_rvalid_q;
    assign d_err    = d_err_q;
    assign d_rdata  = d_rd_q ? ram_rdata : '0;
    assign busy     = !run;

endmodule

// File: tb/tb_hansen_mem_arbiter.sv
// Directed bench for hansen_mem_arbiter with DEPTH=512 and clear-on-reset enabled.
module tb_hansen_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, busy;
    logic [31:0] i_rdata, d_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hansen_mem_arbiter #(.DEPTH(512), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts busy cycles from now; also flags any grant leaking out during clear.
    task automatic clear_wait(input string tag);
        int n    = 0;
        int leak = 0;
        while (busy && n < 2000) begin
            if (i_gnt || d_gnt) leak++;
            n++;
            tick();
        end
        chk({tag, "_busy_cycles"}, n, 512);
        chk({tag, "_gnt_leak"}, leak, 0);
    endtask

    // One access on port I (is_d=0) or D (is_d=1), response checked one cycle after grant.
    task automatic acc(input string tag, input bit is_d, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input bit exp_err);
        int w = 0;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        #1;
        while (!(is_d ? d_gnt : i_gnt) && w < 10) begin
            tick();
            w++;
        end
        chk({tag, "_gnt"}, {31'b0, is_d ? d_gnt : i_gnt}, 1);
        tick();
        i_req = 1'b0;
        d_req = 1'b0;
        if (is_d) begin
            chk({tag, "_rvalid"}, {31'b0, d_rvalid}, 1);
            chk({tag, "_rdata"}, d_rdata, exp_rdata);
            chk({tag, "_err"}, {31'b0, d_err}, {31'b0, exp_err});
        end else begin
            chk({tag, "_rvalid"}, {31'b0, i_rvalid}, 1);
            chk({tag, "_rdata"}, i_rdata, exp_rdata);
            chk({tag, "_err"}, {31'b0, i_err}, {31'b0, exp_err});
        end
    endtask

    initial begin
        reset = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = '0; d_wdata = '0;
        tick();
        tick();
        chk("rst_busy", {31'b0, busy}, 1);
        chk("rst_valids", {28'b0, i_rvalid, d_rvalid, i_err, d_err}, 0);
        chk("rst_gnts", {30'b0, i_gnt, d_gnt}, 0);
        chk("rst_rdata", i_rdata | d_rdata, 0);

        // Both requesters waiting through the clear; contention begins at RUN entry.
        i_req = 1'b1; i_addr = 32'h0000_01FC;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0000;
        reset = 1'b0;
        clear_wait("clr1");
        for (int k = 0; k < 6; k++) begin
            bit exp_d;
            exp_d = (k % 2 == 0);
            chk($sformatf("rr%0d_dgnt", k), {31'b0, d_gnt}, {31'b0, exp_d});
            chk($sformatf("rr%0d_ignt", k), {31'b0, i_gnt}, {31'b0, !exp_d});
            tick();
            chk($sformatf("rr%0d_dval", k), {31'b0, d_rvalid}, {31'b0, exp_d});
            chk($sformatf("rr%0d_ival", k), {31'b0, i_rvalid}, {31'b0, !exp_d});
            chk($sformatf("rr%0d_data", k), i_rdata | d_rdata, 0);
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();
        chk("idle_valids", {30'b0, i_rvalid, d_rvalid}, 0);

        acc("i_rd_1fc", 1'b0, 1'b0, 4'h0, 32'h1FC, 32'h0, 32'h0, 1'b0);
        acc("d_wr_10",  1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        acc("i_rd_10",  1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        acc("d_wr_20",  1'b1, 1'b1, 4'hF, 32'h20, 32'h11223344, 32'h0, 1'b0);
        acc("d_wr_be4", 1'b1, 1'b1, 4'b0100, 32'h20, 32'h00AA0000, 32'h0, 1'b0);
        acc("d_rd_20",  1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 32'h11AA3344, 1'b0);
        acc("d_wr_be0", 1'b1, 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b0);
        acc("d_rd_20b", 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 32'h11AA3344, 1'b0);
        acc("d_rd_800", 1'b1, 1'b0, 4'h0, 32'h800, 32'h0, 32'h0, 1'b1);
        acc("i_rd_mis", 1'b0, 1'b0, 4'h0, 32'h3, 32'h0, 32'h0, 1'b1);
        acc("d_wr_4",   1'b1, 1'b1, 4'hF, 32'h4, 32'h00000055, 32'h0, 1'b0);
        acc("d_wr_6",   1'b1, 1'b1, 4'hF, 32'h6, 32'hCAFEF00D, 32'h0, 1'b1);
        acc("d_rd_4",   1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 32'h00000055, 1'b0);

        // Reset mid-clear at clr_cnt=100: clear restarts and runs its full length.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (100) tick();
        chk("mid_busy", {31'b0, busy}, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'b0, busy}, 1);
        tick();
        reset = 1'b0;
        clear_wait("clr2");
        acc("i_rd_10c", 1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 32'h0, 1'b0);

        // Reset while a read response is pending drops it asynchronously.
        acc("d_wr_8", 1'b1, 1'b1, 4'hF, 32'h8, 32'h12345678, 32'h0, 1'b0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
        #1;
        chk("pend_gnt", {31'b0, d_gnt}, 1);
        tick();
        d_req = 1'b0;
        chk("pend_rvalid", {31'b0, d_rvalid}, 1);
        chk("pend_rdata", d_rdata, 32'h12345678);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rvalid", {30'b0, d_rvalid, i_rvalid}, 0);
        chk("async_rdata", d_rdata, 0);
        tick();
        reset = 1'b0;
        chk("post_rvalid", {30'b0, d_rvalid, i_rvalid}, 0);
        clear_wait("clr3");
        chk("post_rvalid2", {30'b0, d_rvalid, i_rvalid}, 0);
        acc("d_rd_8c", 1'b1, 1'b0, 4'h0, 32'h8, 32'h0, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hansen_mem_arbiter.md
# hansen_mem_arbiter

Arbitrates a single-port, one-cycle-latency on-chip RAM between the core's instruction-fetch port and data port, replacing the dual combinational read paths of the SoC top level. It sits between `hansen_core` and the block RAM. It uses a req/gnt/rvalid handshake, round-robin arbitration on contention, and address/alignment checking. After reset it runs a clear sequencer that zeroes the whole RAM before the first grant.

## Interface
- `DEPTH`, 512: RAM size in 32-bit words; power of two, ≥ 2.
- `CLEAR_ON_RESET`, 1: 1 = zero the RAM after reset; 0 = start directly in RUN.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_req`  in  1  instruction read request; held with `i_addr` stable until `i_gnt`.
- `i_addr`  in  32  byte address.
- `i_gnt`  out  1  request accepted this cycle.
- `i_rvalid`  out  1  response valid.
- `i_rdata`  out  32  read data; 0 when `i_rvalid`=0.
- `i_err`  out  1  error flag, qualified by `i_rvalid`.
- `d_req`  in  1  data request; held with its payload stable until `d_gnt`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_be`  in  4  byte enables for writes; ignored on reads.
- `d_addr`  in  32  byte address.
- `d_wdata`  in  32  write data.
- `d_gnt`  out  1  request accepted this cycle.
- `d_rvalid`  out  1  response valid; every granted read or write gets exactly one response.
- `d_rdata`  out  32  read data; 0 for writes, errors, and when `d_rvalid`=0.
- `d_err`  out  1  error flag.
- `busy`  out  1  clear sequence in progress.

## Operation
- **States:** CLEAR, RUN.
- **Reset entry:** reset enters CLEAR with `clr_cnt`=0 when `CLEAR_ON_RESET`=1, otherwise RUN.
- **CLEAR:**
  - Writes 0 (all bytes) to word `clr_cnt` each cycle and increments the counter.
  - After word `DEPTH-1` is written, moves to RUN on the next edge.
  - `busy`=1 and both gnts are 0 throughout.
- **RUN, single requester:** the requesting port is granted.
- **RUN, both requesting:** grant goes to the port not granted last.
  - Pointer `last_gnt` updates on every grant.
  - Reset value is I, so the first contested cycle grants D.
- **Grant limit:** at most one grant per cycle.
- **Word index:** `addr[log2(DEPTH)+1:2]`.
- **Error condition:** `addr[1:0]`≠0 or `addr` ≥ 4·DEPTH.
  - The request is still granted.
  - Response has err=1 and rdata=0; the RAM is not accessed and no write occurs.
- **Writes:** update only the lanes with `d_be[k]`=1 (byte k = bits 8k+7:8k). `d_be`=0 is a legal no-op write that still gets acked.
- **RAM contents:** not reset. Only the CLEAR sequence initialises them.

## Timing
- `gnt` is combinational from `req` and state, in the same cycle.
- `rvalid`, `rdata` and `err` are registered: they appear exactly 1 cycle after `gnt` and are high for 1 cycle.
- Throughput: one access per cycle total across both ports.
- A write granted in cycle N is visible to a read granted in cycle N+1.
- **Reset values:**
  - all gnt, rvalid and err outputs = 0; rdata = 0;
  - `busy` = `CLEAR_ON_RESET`;
  - `last_gnt` = I; `clr_cnt` = 0.
- **Reset mid-operation:**
  - A pending response is dropped and rvalid goes to 0 asynchronously.
  - A clear in progress restarts from word 0.
- `busy` falls in the same cycle the state becomes RUN. The first grant is possible in that cycle.
- A req deasserted before gnt is legal and simply withdrawn; no response is issued.

## Structure
- Shared package `hansen_pkg`:
  - `HANSEN_XLEN`=32;
  - port-select enum `{PORT_I, PORT_D}`;
  - state enum `{ST_CLEAR, ST_RUN}`.
- Sub-module `hansen_bram_sp`:
  - single-port synchronous RAM, `DEPTH`×32;
  - 4 byte-write enables;
  - registered read data, 1-cycle latency;
  - behavioural array so synthesis infers BRAM.
- The arbiter contains the FSM, clear counter, round-robin pointer, range check, and response registers.

## Test plan
- Reset with `DEPTH`=512, `CLEAR_ON_RESET`=1 -> `busy`=1 for exactly 512 cycles with gnts 0; then an I read of 0x1FC -> `i_rdata`=0x00000000, `i_err`=0.
- D write 0xDEADBEEF, `be`=4'hF @0x10; next cycle I read 0x10 -> `i_rvalid` one cycle after `i_gnt`, `i_rdata`=0xDEADBEEF.
- D write 0x11223344 @0x20, then `be`=4'b0100 with data 0x00AA0000; D read 0x20 -> 0x11AA3344.
- `i_req` and `d_req` held high for 6 cycles from reset-exit -> grant order D,I,D,I,D,I; each response arrives on the matching port 1 cycle later.
- D read 0x800 -> `d_err`=1, `d_rdata`=0. D write @0x6 -> `d_err`=1, RAM word 1 unchanged.
- Reset asserted at `clr_cnt`=100, and separately while a read response is pending -> rvalid=0 immediately, no stale response after release, clear restarts and lasts 512 cycles.
